// File: rtl/x2050_ms.sv
// Main-storage control for the x2050 datapath: decodes storage microorders and runs one
// Wishbone pipelined master beat per request, returning read data and stalling the ROS.
module x2050_ms #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 30,
    parameter int unsigned XW = 25
) (
    input  logic          clk,
    input  logic          rst,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [DW-1:0] o_wb_data,
    output logic [3:0]    o_wb_sel,
    input  logic          i_wb_stall,
    input  logic          i_wb_ack,
    input  logic          i_wb_err,
    input  logic [DW-1:0] i_wb_data,
    input  logic [4:0]    i_tr,
    input  logic [2:0]    i_iv,
    input  logic [3:0]    i_wm,
    input  logic [5:0]    i_ab,
    input  logic [4:0]    i_al,
    input  logic [5:0]    i_ss,
    input  logic [23:0]   i_nextiar,
    input  logic [31:0]   i_t_reg,
    input  logic [3:0]    i_bs_reg,
    input  logic          i_ros_clock_on,
    input  logic          i_io_mode,
    output logic          o_ms_busy,
    output logic          o_data_stall,
    output logic          o_data_ready,
    output logic [DW-1:0] o_data_read
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e          state_q, state_d;
    logic [23:0]     sar_q, sar_d;
    logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [3:0]      sel_q, sel_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;

    logic            is_read, is_write, consume, new_req, accept, read_pending, beat_end;
    logic [23:0]     req_sar;
    logic [AW-1:0]   main_addr, local_addr, req_addr;
    logic            unused_ok;

    // tr decodes first; an instruction fetch only applies when tr names no storage action.
    assign is_read  = (i_tr == 5'd9) || ((i_tr != 5'd12) && (i_iv == 3'd4));
    assign is_write = (i_tr == 5'd12);
    assign consume  = (i_tr == 5'd4);
    assign new_req  = is_read || is_write;

    assign req_sar = (i_tr == 5'd9) ? i_t_reg[23:0] : (is_read ? i_nextiar : sar_q);

    always_comb begin
        main_addr        = '0;
        main_addr[21:0]  = req_sar[23:2];
        local_addr       = '0;
        local_addr[XW]   = 1'b1;
        local_addr[9:0]  = req_sar[11:2];
        req_addr         = i_io_mode ? local_addr : main_addr;
    end

    assign o_ms_busy    = (state_q != StIdle);
    assign read_pending = o_ms_busy && !we_q && !ready_q;
    assign o_data_stall = !rst && ((consume && read_pending) || (new_req && o_ms_busy));
    assign accept       = i_ros_clock_on && !o_data_stall;

    // A stalled beat may not complete even if the slave flags ack/err alongside it.
    assign beat_end = ((state_q == StReq && !i_wb_stall) || state_q == StWait)
                      && (i_wb_ack || i_wb_err);

    always_comb begin
        state_d = state_q;
        sar_d   = sar_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        ready_d = ready_q;
        err_d   = err_q;

        if (accept && consume) begin
            ready_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (accept && new_req) begin
                    state_d = StReq;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    err_d   = 1'b0;
                    addr_d  = req_addr;
                    if (is_read) begin
                        sar_d   = req_sar;
                        we_d    = 1'b0;
                        sel_d   = 4'hF;
                        ready_d = 1'b0;
                    end else begin
                        we_d   = 1'b1;
                        sel_d  = (i_bs_reg == 4'h0) ? 4'hF : i_bs_reg;
                        data_d = i_t_reg;
                    end
                end
            end
            StReq: begin
                if (!i_wb_stall) begin
                    stb_d = 1'b0;
                    if (i_wb_ack || i_wb_err) begin
                        state_d = StDone;
                        cyc_d   = 1'b0;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (i_wb_ack || i_wb_err) begin
                    state_d = StDone;
                    cyc_d   = 1'b0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (beat_end) begin
            err_d = i_wb_err && !i_wb_ack;
            if (!we_q) begin
                ready_d = 1'b1;
                rdata_d = i_wb_ack ? i_wb_data : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sar_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            sel_q   <= 4'h0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sar_q   <= sar_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign o_wb_cyc     = cyc_q;
    assign o_wb_stb     = stb_q;
    assign o_wb_we      = we_q;
    assign o_wb_addr    = addr_q;
    assign o_wb_data    = data_q;
    assign o_wb_sel     = sel_q;
    assign o_data_ready = ready_q;
    assign o_data_read  = rdata_q;

    // Reserved ROS fields and the error flag have no consumer in this block yet.
    assign unused_ok = ^{i_wm, i_ab, i_al, i_ss, err_q, req_sar[1:0]};

endmodule

// File: tb/tb_x2050_ms.sv
// Directed bench for x2050_ms against a small Wishbone memory model (64K main words,
// 1K local-store words, err beyond either range).
module tb_x2050_ms;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_init = 1'b1;
    logic        wb_cyc, wb_stb, wb_we;
    logic [29:0] wb_addr;
    logic [31:0] wb_wdata;
    logic [3:0]  wb_sel;
    logic        wb_stall = 1'b0;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;
    logic [31:0] wb_rdata = 32'h0;
    logic [4:0]  tr = 5'd0;
    logic [2:0]  iv = 3'd0;
    logic [23:0] nextiar = 24'h0;
    logic [31:0] t_reg = 32'h0;
    logic [3:0]  bs_reg = 4'h0;
    logic        clk_on = 1'b1;
    logic        io_mode = 1'b0;
    logic        busy, dstall, dready;
    logic [31:0] dread;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [0:65535];
    logic [31:0] ls  [0:1023];

    always #5 clk = ~clk;

    x2050_ms dut (
        .clk            (clk),
        .rst            (rst),
        .o_wb_cyc       (wb_cyc),
        .o_wb_stb       (wb_stb),
        .o_wb_we        (wb_we),
        .o_wb_addr      (wb_addr),
        .o_wb_data      (wb_wdata),
        .o_wb_sel       (wb_sel),
        .i_wb_stall     (wb_stall),
        .i_wb_ack       (wb_ack),
        .i_wb_err       (wb_err),
        .i_wb_data      (wb_rdata),
        .i_tr           (tr),
        .i_iv           (iv),
        .i_wm           (4'h0),
        .i_ab           (6'h0),
        .i_al           (5'h0),
        .i_ss           (6'h0),
        .i_nextiar      (nextiar),
        .i_t_reg        (t_reg),
        .i_bs_reg       (bs_reg),
        .i_ros_clock_on (clk_on),
        .i_io_mode      (io_mode),
        .o_ms_busy      (busy),
        .o_data_stall   (dstall),
        .o_data_ready   (dready),
        .o_data_read    (dread)
    );

    // Slave acks (or errs) one clock after each accepted beat.
    always @(posedge clk) begin
        wb_ack <= 1'b0;
        wb_err <= 1'b0;
        if (mem_init) begin
            mem[16'h0040] <= 32'h11223344;
            mem[16'h0041] <= 32'h55667788;
            ls[4]         <= 32'hCAFEF00D;
        end else if (wb_cyc && wb_stb && !wb_stall) begin
            if (wb_addr[25]) begin
                if (wb_addr[24:10] != 15'h0) begin
                    wb_err <= 1'b1;
                end else begin
                    wb_ack   <= 1'b1;
                    wb_rdata <= ls[wb_addr[9:0]];
                    if (wb_we)
                        for (int b = 0; b < 4; b++)
                            if (wb_sel[b]) ls[wb_addr[9:0]][8*b +: 8] <= wb_wdata[8*b +: 8];
                end
            end else if (wb_addr[29:16] != 14'h0) begin
                wb_err <= 1'b1;
            end else begin
                wb_ack   <= 1'b1;
                wb_rdata <= mem[wb_addr[15:0]];
                if (wb_we)
                    for (int b = 0; b < 4; b++)
                        if (wb_sel[b]) mem[wb_addr[15:0]][8*b +: 8] <= wb_wdata[8*b +: 8];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        // Reset for two clocks with idle microcode.
        step();
        check("rst_stall", 32'(dstall), 0);
        step();
        check("rst_cyc", 32'(wb_cyc), 0);
        check("rst_stb", 32'(wb_stb), 0);
        check("rst_we", 32'(wb_we), 0);
        check("rst_addr", 32'(wb_addr), 0);
        check("rst_wdata", wb_wdata, 0);
        check("rst_sel", 32'(wb_sel), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(dready), 0);
        check("rst_dread", dread, 0);
        rst = 1'b0;
        mem_init = 1'b0;
        step();
        step();
        check("idle_cyc", 32'(wb_cyc), 0);

        // Basic read of word 0x40.
        tr = 5'd9; t_reg = 32'h100;
        step();
        tr = 5'd0;
        check("rd_cyc", 32'(wb_cyc), 1);
        check("rd_stb", 32'(wb_stb), 1);
        check("rd_addr", 32'(wb_addr), 32'h40);
        check("rd_we", 32'(wb_we), 0);
        check("rd_sel", 32'(wb_sel), 32'hF);
        check("rd_busy", 32'(busy), 1);
        step();
        check("rd_stb_drop", 32'(wb_stb), 0);
        check("rd_wait_cyc", 32'(wb_cyc), 1);
        check("rd_not_ready", 32'(dready), 0);
        step();
        check("rd_ready", 32'(dready), 1);
        check("rd_data", dread, 32'h11223344);
        check("rd_cyc_drop", 32'(wb_cyc), 0);
        step();
        check("rd_idle", 32'(busy), 0);

        // Read then consume: stall until data arrives, released on the consume cycle.
        tr = 5'd9; t_reg = 32'h100;
        step();
        tr = 5'd4;
        #1;
        check("cons_ready_clr", 32'(dready), 0);
        check("cons_stall0", 32'(dstall), 1);
        step();
        check("cons_stall1", 32'(dstall), 1);
        step();
        check("cons_ready", 32'(dready), 1);
        check("cons_release", 32'(dstall), 0);
        step();
        tr = 5'd0;
        #1;
        check("cons_taken", 32'(dready), 0);
        check("cons_nostall", 32'(dstall), 0);
        check("cons_data", dread, 32'h11223344);

        // Byte-masked write to current SAR (0x100).
        tr = 5'd12; t_reg = 32'hDEADBEEF; bs_reg = 4'b0011;
        step();
        tr = 5'd0;
        check("wr_we", 32'(wb_we), 1);
        check("wr_sel", 32'(wb_sel), 32'h3);
        check("wr_data", wb_wdata, 32'hDEADBEEF);
        check("wr_addr", 32'(wb_addr), 32'h40);
        step(); step(); step();
        check("wr_ready_kept", 32'(dready), 0);
        check("wr_dread_kept", dread, 32'h11223344);
        check("wr_idle", 32'(busy), 0);

        // Read back merged word.
        tr = 5'd9; t_reg = 32'h100; bs_reg = 4'h0;
        step();
        tr = 5'd0;
        step(); step();
        check("rb_data", dread, 32'h1122BEEF);
        check("rb_ready", 32'(dready), 1);
        step();

        // Write with zero byte mask drives all lanes.
        tr = 5'd12; t_reg = 32'h0;
        step();
        tr = 5'd0;
        check("wr_sel_full", 32'(wb_sel), 32'hF);
        step(); step(); step();

        // Out-of-range read errs.
        tr = 5'd9; t_reg = 32'h40000;
        step();
        tr = 5'd0;
        check("err_addr", 32'(wb_addr), 32'h10000);
        step(); step();
        check("err_ready", 32'(dready), 1);
        check("err_data", dread, 0);
        step();
        check("err_idle", 32'(busy), 0);

        // Local-store read, io_mode latched at acceptance.
        io_mode = 1'b1; tr = 5'd9; t_reg = 32'h10;
        step();
        tr = 5'd0; io_mode = 1'b0;
        check("ls_addr", 32'(wb_addr), 32'h2000004);
        step(); step();
        check("ls_data", dread, 32'hCAFEF00D);
        step();

        // Slave stall holds stb for two extra clocks.
        tr = 5'd9; t_reg = 32'h104;
        step();
        tr = 5'd0; wb_stall = 1'b1;
        step();
        check("st_stb1", 32'(wb_stb), 1);
        step();
        check("st_stb2", 32'(wb_stb), 1);
        wb_stall = 1'b0;
        step();
        check("st_stb_drop", 32'(wb_stb), 0);
        check("st_not_ready", 32'(dready), 0);
        step();
        check("st_ready", 32'(dready), 1);
        check("st_data", dread, 32'h55667788);
        step();

        // New request while busy stalls.
        tr = 5'd9; t_reg = 32'h100;
        step();
        #1;
        check("busy_stall", 32'(dstall), 1);
        tr = 5'd0;
        step(); step(); step();

        // Instruction fetch from nextiar.
        iv = 3'd4; nextiar = 24'h104;
        step();
        iv = 3'd0;
        check("if_addr", 32'(wb_addr), 32'h41);
        step(); step();
        check("if_data", dread, 32'h55667788);
        step();

        // No acceptance with the ROS clock off.
        clk_on = 1'b0; tr = 5'd9; t_reg = 32'h100;
        step();
        check("clkoff_busy", 32'(busy), 0);
        clk_on = 1'b1; tr = 5'd0;

        // Reset mid-cycle; the late ack is ignored.
        tr = 5'd9; t_reg = 32'h100;
        step();
        tr = 5'd0; rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_cyc", 32'(wb_cyc), 0);
        check("mrst_busy", 32'(busy), 0);
        step();
        check("mrst_ready", 32'(dready), 0);
        check("mrst_dread", dread, 0);
        check("mrst_cyc2", 32'(wb_cyc), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
